// File: rtl/a51_pkg.sv
// Shared constants, state encoding and majority helper for the A5/1 keystream block.
package a51_pkg;

  localparam int KEY_W      = 64;
  localparam int FRAME_W    = 22;
  localparam int MIX_CYCLES = 100;
  localparam int KS_LEN     = 228;

  localparam int CNT_W  = 8;
  localparam int KEY_IDX_W   = $clog2(KEY_W);
  localparam int FRAME_IDX_W = $clog2(FRAME_W);

  // Terminal counts; MIX runs one extra step to expose the first output bit.
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES);
  localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_LEN - 1);

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    GEN
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr.sv
// One A5/1 shift register: clear, step with tap feedback, optional injected bit.
module a51_lfsr
  import a51_pkg::*;
#(
  parameter int              LEN      = 19,
  parameter logic [LEN-1:0]  TAP_MASK = {LEN{1'b0}},
  parameter int              CLK_BIT  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  input  logic inject,
  output logic msb,
  output logic clk_tap
);

  logic [LEN-1:0] value;
  logic           fb;

  assign fb      = (^(value & TAP_MASK)) ^ inject;
  assign msb     = value[LEN-1];
  assign clk_tap = value[CLK_BIT];

  // Clear wins over step so a burst restart always begins from all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (step) begin
      value <= {value[LEN-2:0], fb};
    end
  end

endmodule

// File: rtl/a51_keystream_ctrl.sv
// A5/1 burst sequencer: key load, frame load, mixing, then KS_LEN keystream bits.
// Build option A51_FRAME_AUTOINC_EN: back-to-back bursts with frame+1 while start is held.
module a51_keystream_ctrl
  import a51_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               ks_bit,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cur
);

  // Stream contract: ks_bit is transferred on a rising edge where ks_valid and
  // ks_ready are both high; while ks_valid=1 and ks_ready=0 the bit holds and
  // ks_valid stays asserted.

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [KEY_W-1:0]   key_q;

  logic regular, irregular, inject, clear, accept, last_hs;
  logic m;
  logic r1_msb, r2_msb, r3_msb;
  logic r1_clk, r2_clk, r3_clk;
  logic r1_step, r2_step, r3_step;
`ifdef A51_FRAME_AUTOINC_EN
  logic reload;
`endif

  assign m       = maj3(r1_clk, r2_clk, r3_clk);
  assign r1_step = regular | (irregular & (r1_clk == m));
  assign r2_step = regular | (irregular & (r2_clk == m));
  assign r3_step = regular | (irregular & (r3_clk == m));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    regular   = 1'b0;
    irregular = 1'b0;
    inject    = 1'b0;
    clear     = 1'b0;
    accept    = 1'b0;
    last_hs   = 1'b0;
`ifdef A51_FRAME_AUTOINC_EN
    reload    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          clear     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        regular = 1'b1;
        inject  = key_q[cnt[KEY_IDX_W-1:0]];
        if (cnt == KEY_LAST) begin
          cnt_nxt   = '0;
          state_nxt = LOAD_FRAME;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LOAD_FRAME: begin
        regular = 1'b1;
        inject  = frame_cur[cnt[FRAME_IDX_W-1:0]];
        if (cnt == FRAME_LAST) begin
          cnt_nxt   = '0;
          state_nxt = MIX;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      MIX: begin
        irregular = 1'b1;
        if (cnt == MIX_LAST) begin
          cnt_nxt   = '0;
          state_nxt = GEN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GEN: begin
        if (ks_ready) begin
          irregular = 1'b1;
          if (cnt == KS_LAST) begin
            last_hs   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`ifdef A51_FRAME_AUTOINC_EN
            if (start) begin
              reload    = 1'b1;
              clear     = 1'b1;
              state_nxt = LOAD_KEY;
            end
`endif
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_q     <= '0;
      frame_cur <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= last_hs;
      if (accept) begin
        key_q     <= key;
        frame_cur <= frame;
      end
`ifdef A51_FRAME_AUTOINC_EN
      else if (reload) begin
        frame_cur <= frame_cur + FRAME_W'(1);
      end
`endif
    end
  end

  assign busy     = (state != IDLE);
  assign ks_valid = (state == GEN);
  assign ks_bit   = ks_valid & (r1_msb ^ r2_msb ^ r3_msb);

  a51_lfsr #(.LEN(R1_LEN), .TAP_MASK(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .step(r1_step), .inject(inject),
    .msb(r1_msb), .clk_tap(r1_clk)
  );

  a51_lfsr #(.LEN(R2_LEN), .TAP_MASK(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .step(r2_step), .inject(inject),
    .msb(r2_msb), .clk_tap(r2_clk)
  );

  a51_lfsr #(.LEN(R3_LEN), .TAP_MASK(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .step(r3_step), .inject(inject),
    .msb(r3_msb), .clk_tap(r3_clk)
  );

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// Bench for a51_keystream_ctrl: reference A5/1 model feeds an expected-bit queue.
module tb_a51_keystream_ctrl;
  import a51_pkg::*;

  localparam logic [63:0] KEY0 = 64'hEFCDAB8967452312;
  localparam logic [21:0] F0   = 22'h134;
  localparam logic [63:0] KEY4 = 64'h0123456789ABCDEF;
  localparam logic [21:0] F4   = 22'h25A5A;
  localparam logic [63:0] KEY5 = 64'hDEADBEEF0BADF00D;
  localparam logic [21:0] F5   = 22'h1F00F;
  localparam int          LAT  = 188;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  key = '0;
  logic [21:0]  frame = '0;
  logic         ks_ready = 1'b1;
  logic         busy, ks_bit, ks_valid, done;
  logic [21:0]  frame_cur;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  int   hs_in_burst = 0;
  logic done_pend = 1'b0;
  logic prev_stall = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  a51_keystream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .frame(frame),
    .busy(busy), .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .done(done), .frame_cur(frame_cur)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference A5/1 in the classic software form: whole-word shifts and parity.
  function automatic logic [31:0] clk_one(input logic [31:0] r, input logic [31:0] mask,
                                          input logic [31:0] taps);
    return ((r << 1) & mask) | 32'(^(r & taps));
  endfunction

  function automatic logic [KS_LEN-1:0] model_ks(input logic [63:0] k, input logic [21:0] f);
    logic [31:0] a, b, c;
    logic [KS_LEN-1:0] o;
    logic bin, mj;
    int votes;
    a = '0; b = '0; c = '0; o = '0;
    for (int i = 0; i < 86; i++) begin
      a = clk_one(a, 32'h7FFFF, 32'h072000);
      b = clk_one(b, 32'h3FFFFF, 32'h300000);
      c = clk_one(c, 32'h7FFFFF, 32'h700080);
      if (i < 64) bin = k[i];
      else        bin = f[i-64];
      a[0] = a[0] ^ bin;
      b[0] = b[0] ^ bin;
      c[0] = c[0] ^ bin;
    end
    for (int i = 0; i < 100 + KS_LEN; i++) begin
      votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
      mj = (votes >= 2);
      if (a[8]  == mj) a = clk_one(a, 32'h7FFFF, 32'h072000);
      if (b[10] == mj) b = clk_one(b, 32'h3FFFFF, 32'h300000);
      if (c[10] == mj) c = clk_one(c, 32'h7FFFFF, 32'h700080);
      if (i >= 100) o[i-100] = a[18] ^ b[21] ^ c[22];
    end
    return o;
  endfunction

  task automatic push_burst(input logic [63:0] k, input logic [21:0] f);
    logic [KS_LEN-1:0] mb;
    mb = model_ks(k, f);
    for (int j = 0; j < KS_LEN; j++) exp_q.push_back(mb[j]);
  endtask

  // Ends 1 time unit after the accepting edge, with key/frame scrambled.
  task automatic launch(input logic [63:0] k, input logic [21:0] f);
    @(posedge clk); #1;
    key = k; frame = f; start = 1'b1;
    push_burst(k, f);
    @(posedge clk); #1;
    start = 1'b0; key = ~k; frame = ~f;
  endtask

  // Counts rising edges from the accepting edge through the one that raises ks_valid.
  task automatic measure_latency(output int lat);
    lat = 1;
    while (lat < 400) begin
      @(negedge clk);
      if (ks_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare against the expected-bit queue and the done rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hs_in_burst = 0;
      done_pend   = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      check("done_pulse", done, done_pend);
      done_pend = 1'b0;
      if (prev_stall) check("valid_hold", ks_valid, 1);
      prev_stall = ks_valid && !ks_ready;
      if (ks_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ks_extra actual=valid required=no bit pending");
        end else begin
          check("ks_bit", ks_bit, exp_q[0]);
          if (ks_ready) begin
            void'(exp_q.pop_front());
            hs_in_burst++;
            if (hs_in_burst == KS_LEN) begin
              hs_in_burst = 0;
              done_pend   = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [KS_LEN-1:0] mb;
    logic [119:0] lit_a, lit_b;
    logic [113:0] va, vb;
    logic [7:0]   first8;
    int lat;
    bit seen;
    int cnt;

    // Model pinned to the published test vector.
    lit_a = 120'h534EAA582FE8151AB6E1855A728C00;
    lit_b = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    mb = model_ks(KEY0, F0);
    for (int j = 0; j < 114; j++) begin
      va[113-j] = mb[j];
      vb[113-j] = mb[114+j];
    end
    for (int j = 0; j < 8; j++) first8[7-j] = mb[j];
    check("model_first8", first8, 8'h53);
    check("model_atob", va, lit_a[119:6]);
    check("model_btoa", vb, lit_b[119:6]);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", ks_valid, 0);
    check("rst_bit", ks_bit, 0);
    check("rst_done", done, 0);
    check("rst_frame_cur", frame_cur, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Reference vector, always ready
    launch(KEY0, F0);
    check("t2_busy", busy, 1);
    measure_latency(lat);
    check("t2_latency", lat, LAT);
    wait_done(600, seen);
    check("t2_done_seen", seen, 1);
    check("t2_busy_end", busy, 0);
    check("t2_valid_end", ks_valid, 0);
    check("t2_frame_cur", frame_cur, F0);
    check("t2_drained", exp_q.size(), 0);

    // Same vector with random back-pressure
    rand_ready = 1'b1;
    launch(KEY0, F0);
    measure_latency(lat);
    check("t3_latency", lat, LAT);
    wait_done(2000, seen);
    check("t3_done_seen", seen, 1);
    check("t3_drained", exp_q.size(), 0);
    rand_ready = 1'b0;

    // start pulses while busy are ignored
    launch(KEY4, F4);
    repeat (4) @(posedge clk);
    #1;
    check("t4_busy_5", busy, 1);
    key = KEY5; frame = F5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (84) @(posedge clk);
    #1;
    check("t4_busy_90", busy, 1);
    key = KEY5; frame = F5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(600, seen);
    check("t4_done_seen", seen, 1);
    check("t4_frame_cur", frame_cur, F4);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy || ks_valid) cnt++;
    end
    check("t4_no_second_burst", cnt, 0);

    // Reset in the middle of mixing
    launch(KEY5, F5);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_valid", ks_valid, 0);
    check("t1_done", done, 0);
    check("t1_frame_cur", frame_cur, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (done || busy || ks_valid) cnt++;
    end
    check("t1_quiet_after_reset", cnt, 0);
    launch(KEY5, F5);
    measure_latency(lat);
    check("t1_latency", lat, LAT);
    wait_done(600, seen);
    check("t1_done_seen", seen, 1);
    check("t1_frame_cur_end", frame_cur, F5);

`ifndef A51_FRAME_AUTOINC_EN
    // start raised in the done cycle is accepted at the next edge
    check("t5_idle_in_done", busy, 0);
    key = KEY4; frame = F0; start = 1'b1;
    push_burst(KEY4, F0);
    @(posedge clk); #1;
    start = 1'b0; key = '0; frame = '0;
    check("t5_busy", busy, 1);
    measure_latency(lat);
    check("t5_latency", lat, LAT);
    wait_done(600, seen);
    check("t5_done_seen", seen, 1);
    check("t5_frame_cur", frame_cur, F0);
`else
    // Held start chains a second burst with frame wrapping to zero
    @(posedge clk); #1;
    key = KEY0; frame = 22'h3FFFFF; start = 1'b1;
    push_burst(KEY0, 22'h3FFFFF);
    push_burst(KEY0, 22'h000000);
    @(posedge clk); #1;
    key = '0; frame = '0;
    wait_done(600, seen);
    check("t6_done1_seen", seen, 1);
    check("t6_busy_kept", busy, 1);
    check("t6_frame_wrap", frame_cur, 0);
    check("t6_queue_second", exp_q.size(), KS_LEN);
    start = 1'b0;
    measure_latency(lat);
    check("t6_latency", lat, LAT);
    wait_done(600, seen);
    check("t6_done2_seen", seen, 1);
    check("t6_busy_end", busy, 0);
`endif

    repeat (5) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
